// File: rtl/sha3_pkg.sv
// Shared constants and FSM state type for the SHA3-512 block packer.
package sha3_pkg;
    localparam int         RATE_BYTES = 72;
    localparam int         RATE_BITS  = 576;
    localparam logic [7:0] PAD_DOMAIN = 8'h06;
    localparam logic [7:0] PAD_FINAL  = 8'h80;

    typedef enum logic [1:0] {IDLE, FETCH, PAD, EMIT} state_t;
endpackage

// File: rtl/sha3_pad_insert.sv
// Combinational SHA-3 pad10*1 insertion: domain byte at byte_ptr, final bit in the top byte.
module sha3_pad_insert
    import sha3_pkg::*;
#(
    parameter int PTR_W = 7
) (
    input  logic [RATE_BITS-1:0] blk,
    input  logic [PTR_W-1:0]     byte_ptr,
    input  logic                 fresh,
    output logic [RATE_BITS-1:0] padded
);

    always_comb begin
        padded = fresh ? '0 : blk;
        if (fresh) begin
            padded[7:0] = padded[7:0] | PAD_DOMAIN;
        end else if (byte_ptr < PTR_W'(RATE_BYTES)) begin
            padded[8*byte_ptr +: 8] = padded[8*byte_ptr +: 8] | PAD_DOMAIN;
        end
        // A domain byte landing on byte 71 merges with the final bit into 0x86.
        padded[RATE_BITS-1 -: 8] = padded[RATE_BITS-1 -: 8] | PAD_FINAL;
    end

endmodule

// File: rtl/sha3_block_packer.sv
// Packs 16-bit FIFO words into padded 576-bit SHA3-512 rate blocks.
// Optional SHA3_PACK_STATS_EN adds the blk_count handoff counter port.
module sha3_block_packer
    import sha3_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int RATE_BYTES = 72,
    parameter int LEN_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        msg_len,
    output logic                    busy,
    output logic                    fifo_rd,
    input  logic [WORD_W-1:0]       fifo_data,
    input  logic                    fifo_empty,
    output logic                    blk_valid,
    input  logic                    blk_ready,
    output logic [8*RATE_BYTES-1:0] blk_data,
    output logic                    blk_last
`ifdef SHA3_PACK_STATS_EN
    ,
    output logic [15:0]             blk_count
`endif
);

    localparam int             BLK_W  = 8 * RATE_BYTES;
    localparam int             PTR_W  = $clog2(RATE_BYTES + 1);
    localparam logic [PTR_W-1:0] SLOTS = PTR_W'(RATE_BYTES / 2);
    localparam logic [PTR_W-1:0] FULL  = PTR_W'(RATE_BYTES);

    state_t             state, state_nxt;
    logic [BLK_W-1:0]   blk_p1;
    logic [BLK_W-1:0]   padded;
    logic [PTR_W-1:0]   byte_ptr;
    logic [PTR_W-1:0]   issued;
    logic [LEN_W-1:0]   bytes_left;
    logic [LEN_W-1:0]   words_left;
    logic               vld_p1;
    logic               last_r;
    logic               take2;
    logic               fresh;

    assign take2    = (bytes_left >= LEN_W'(2));
    assign fresh    = (byte_ptr == '0);
    assign busy     = (state != IDLE);
    assign blk_data = blk_p1;
    assign blk_last = last_r;

    sha3_pad_insert #(.PTR_W(PTR_W)) u_pad (
        .blk      (blk_p1),
        .byte_ptr (byte_ptr),
        .fresh    (fresh),
        .padded   (padded)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fifo_rd   = 1'b0;
        blk_valid = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = FETCH;
            FETCH: begin
                fifo_rd = !fifo_empty && (words_left != '0) && (issued < SLOTS);
                // A full block always emits first; a message ending on a boundary pads a fresh block afterwards.
                if (byte_ptr == FULL)                      state_nxt = EMIT;
                else if ((bytes_left == '0) && !vld_p1)    state_nxt = PAD;
            end
            PAD:  state_nxt = EMIT;
            EMIT: begin
                blk_valid = 1'b1;
                if (blk_ready) state_nxt = last_r ? IDLE : FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture stage: word read in cycle N lands in the block register at the end of cycle N+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_p1     <= '0;
            byte_ptr   <= '0;
            issued     <= '0;
            bytes_left <= '0;
            words_left <= '0;
            vld_p1     <= 1'b0;
            last_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bytes_left <= msg_len;
                        words_left <= (msg_len >> 1) + LEN_W'(msg_len[0]);
                        byte_ptr   <= '0;
                        issued     <= '0;
                        vld_p1     <= 1'b0;
                        last_r     <= 1'b0;
                    end
                end
                FETCH: begin
                    vld_p1 <= fifo_rd;
                    if (fifo_rd) begin
                        issued     <= issued + PTR_W'(1);
                        words_left <= words_left - LEN_W'(1);
                    end
                    if (vld_p1) begin
                        blk_p1[8*byte_ptr +: 8] <= fifo_data[15:8];
                        if (take2) begin
                            blk_p1[8*(byte_ptr + PTR_W'(1)) +: 8] <= fifo_data[7:0];
                            byte_ptr   <= byte_ptr + PTR_W'(2);
                            bytes_left <= bytes_left - LEN_W'(2);
                        end else begin
                            byte_ptr   <= byte_ptr + PTR_W'(1);
                            bytes_left <= bytes_left - LEN_W'(1);
                        end
                    end
                end
                PAD: begin
                    blk_p1 <= padded;
                    last_r <= 1'b1;
                end
                EMIT: begin
                    if (blk_ready) begin
                        blk_p1   <= '0;
                        byte_ptr <= '0;
                        issued   <= '0;
                        last_r   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SHA3_PACK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)                         blk_count <= '0;
        else if (blk_valid && blk_ready) blk_count <= blk_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_sha3_block_packer.sv
// Randomized self-checking bench for sha3_block_packer against a byte-level padding model.
module tb_sha3_block_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [15:0]  msg_len = '0;
    logic         busy;
    logic         fifo_rd;
    logic [15:0]  fifo_data = '0;
    logic         fifo_empty = 1'b1;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic [575:0] blk_data;
    logic         blk_last;
`ifdef SHA3_PACK_STATS_EN
    logic [15:0]  blk_count;
`endif

    sha3_block_packer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .msg_len    (msg_len),
        .busy       (busy),
        .fifo_rd    (fifo_rd),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_data   (blk_data),
        .blk_last   (blk_last)
`ifdef SHA3_PACK_STATS_EN
        ,
        .blk_count  (blk_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [575:0] d;
        logic         last;
    } blk_t;

    int           checks = 0;
    int           errors = 0;
    blk_t         exp_q[$];
    blk_t         e;
    logic [15:0]  fq[$];
    logic [15:0]  src[$];
    logic [7:0]   msg[$];
    int           rd_count = 0;
    int           n_blk = 0;
    logic [575:0] first_blk, last_blk, lit_pad, lit_abc;
    logic [15:0]  hs_total = '0;
    bit           stall_en = 1'b0;
    bit           hold_mode = 1'b0;
    int           hold_cnt = 0;
    bit           prev_hold = 1'b0;
    logic [575:0] prev_data;
    logic         prev_last;

    task automatic check(input string name, input logic [575:0] got, input logic [575:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Reference: split message into 72-byte blocks; the tail (possibly empty) gets 06 ... 80.
    task automatic build_expected();
        int   n, full, rem;
        blk_t b;
        n    = msg.size();
        full = n / 72;
        rem  = n - 72 * full;
        for (int k = 0; k < full; k++) begin
            b.d = '0;
            for (int j = 0; j < 72; j++) b.d[8*j +: 8] = msg[72*k + j];
            b.last = 1'b0;
            exp_q.push_back(b);
        end
        b.d = '0;
        for (int j = 0; j < rem; j++) b.d[8*j +: 8] = msg[72*full + j];
        b.d[8*rem +: 8] = b.d[8*rem +: 8] | 8'h06;
        b.d[575:568]    = b.d[575:568] | 8'h80;
        b.last = 1'b1;
        exp_q.push_back(b);
    endtask

    // FIFO model: registered output, one word per read strobe.
    always @(posedge clk) begin
        if (!rst && fifo_rd) begin
            rd_count++;
            checks++;
            if (fq.size() == 0) begin
                errors++;
                $display("FAIL fifo_underflow got read want none");
            end else begin
                fifo_data <= fq.pop_front();
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
            hold_cnt  = 0;
            hs_total  = '0;
        end else begin
            if (fifo_rd) begin
                check("rd_while_empty", fifo_empty, 0);
                check("rd_in_emit", blk_valid, 0);
            end
            if (prev_hold) begin
                check("hold_valid", blk_valid, 1);
                check("hold_data", blk_data, prev_data);
                check("hold_last", blk_last, prev_last);
            end
            if (blk_valid && hold_mode && hold_cnt < 10) begin
                blk_ready = 1'b0;
                hold_cnt++;
            end else begin
                blk_ready = ($urandom_range(0, 2) != 0);
            end
            if (blk_valid && blk_ready) begin
                hold_cnt = 0;
                hs_total = hs_total + 16'd1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_block got %0h want none", blk_data);
                end else begin
                    e = exp_q.pop_front();
                    check("blk_data", blk_data, e.d);
                    check("blk_last", blk_last, e.last);
                end
                if (n_blk == 0) first_blk = blk_data;
                last_blk = blk_data;
                n_blk++;
            end
            prev_hold = blk_valid && !blk_ready;
            prev_data = blk_data;
            prev_last = blk_last;
        end
        fifo_empty = (fq.size() == 0) || (stall_en && ($urandom_range(0, 2) == 0));
    end

    task automatic check_reset();
        check("rst_busy", busy, 0);
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_blk_valid", blk_valid, 0);
        check("rst_blk_last", blk_last, 0);
        check("rst_blk_data", blk_data, 0);
`ifdef SHA3_PACK_STATS_EN
        check("rst_blk_count", blk_count, 0);
`endif
    endtask

    task automatic run_msg(input int len, input bit dbl);
        int nw, t;
        nw = (len + 1) / 2;
        msg.delete();
        while (src.size() < nw) src.push_back(16'($urandom));
        for (int i = 0; i < nw; i++) begin
            fq.push_back(src[i]);
            msg.push_back(src[i][15:8]);
            if (2 * i + 1 < len) msg.push_back(src[i][7:0]);
        end
        src.delete();
        build_expected();
        n_blk    = 0;
        rd_count = 0;
        @(negedge clk);
        start   = 1'b1;
        msg_len = 16'(len);
        @(negedge clk);
        start = 1'b0;
        if (dbl) begin
            repeat (5) @(negedge clk);
            start   = 1'b1;
            msg_len = 16'd7;
            @(negedge clk);
            start = 1'b0;
        end
        t = 0;
        while (busy && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("done_in_time", (t < 20000), 1);
        check("reads", rd_count, nw);
        check("blocks_pending", exp_q.size(), 0);
`ifdef SHA3_PACK_STATS_EN
        check("blk_count", blk_count, hs_total);
`endif
    endtask

    initial begin
        lit_pad          = '0;
        lit_pad[7:0]     = 8'h06;
        lit_pad[575:568] = 8'h80;
        lit_abc          = '0;
        lit_abc[31:0]    = 32'h0663_6261;
        lit_abc[575:568] = 8'h80;

        repeat (3) @(negedge clk);
        check_reset();
        rst = 1'b0;

        run_msg(0, 1'b0);
        check("len0_blocks", n_blk, 1);
        check("len0_block", last_blk, lit_pad);

        src = '{16'h6162, 16'h63FF};
        run_msg(3, 1'b0);
        check("len3_blocks", n_blk, 1);
        check("len3_block", last_blk, lit_abc);

        run_msg(71, 1'b0);
        check("len71_blocks", n_blk, 1);
        check("len71_byte71", last_blk[575:568], 8'h86);
        check("len71_byte70", last_blk[567:560], msg[70]);

        run_msg(72, 1'b0);
        check("len72_blocks", n_blk, 2);
        check("len72_byte71", first_blk[575:568], msg[71]);
        check("len72_padblk", last_blk, lit_pad);

        stall_en  = 1'b1;
        hold_mode = 1'b1;
        run_msg(150, 1'b1);
        hold_mode = 1'b0;

        for (int i = 0; i < 12; i++) begin
            int len;
            stall_en = bit'($urandom_range(0, 1));
            case (i % 4)
                0:       len = 144;
                1:       len = 1 + 72 * int'($urandom_range(0, 2));
                2:       len = 2;
                default: len = int'($urandom_range(0, 300));
            endcase
            run_msg(len, (len >= 40));
        end
        stall_en = 1'b0;

        for (int i = 0; i < 50; i++) fq.push_back(16'($urandom));
        @(negedge clk);
        start   = 1'b1;
        msg_len = 16'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset();
        rst = 1'b0;
        fq.delete();
        exp_q.delete();
        src = '{16'h6162, 16'h63FF};
        run_msg(3, 1'b0);
        check("post_rst_block", last_blk, lit_abc);
`ifdef SHA3_PACK_STATS_EN
        check("post_rst_count", blk_count, 16'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
